// File: rtl/eth_fcs_append.sv
// Byte-wide AXI-Stream stage: zero-pads short Ethernet frames to a minimum
// length and appends the IEEE 802.3 CRC-32 FCS with zero data latency.
module eth_fcs_append #(
    parameter int MIN_FRAME_LEN = 60,
    parameter int LEN_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_axis_tdata_i,
    input  logic             s_axis_tvalid_i,
    output logic             s_axis_tready_o,
    input  logic             s_axis_tlast_i,
    output logic [7:0]       m_axis_tdata_o,
    output logic             m_axis_tvalid_o,
    input  logic             m_axis_tready_i,
    output logic             m_axis_tlast_o,
    output logic             frame_done_o,
    output logic [LEN_W-1:0] frame_len_o
);

    typedef enum logic [1:0] {IDLE, DATA, PAD, FCS} state_t;

    localparam logic [31:0]      POLY    = 32'hEDB88320;
    localparam logic [LEN_W-1:0] CNT_MAX = '1;
    localparam logic [LEN_W:0]   MIN_L   = (LEN_W+1)'(MIN_FRAME_LEN);

    state_t           state_q, state_d;
    logic [31:0]      crc_q, crc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [1:0]       idx_q, idx_d;
    logic             done_q, done_d;

    logic [7:0]       m_data;
    logic             m_valid, m_last, s_ready;
    logic [LEN_W-1:0] cnt_inc;
    logic [LEN_W:0]   cnt_nxt;
    logic [31:0]      fcs;
    logic [7:0]       fcs_byte;

    function automatic logic [31:0] crc_step(input logic [31:0] c,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
        end
        return r;
    endfunction

    // cnt_nxt is one bit wider so the pad comparison cannot wrap
    assign cnt_nxt = {1'b0, cnt_q} + 1'b1;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign fcs     = ~crc_q;

    always_comb begin
        fcs_byte = fcs[7:0];
        unique case (idx_q)
            2'd0: fcs_byte = fcs[7:0];
            2'd1: fcs_byte = fcs[15:8];
            2'd2: fcs_byte = fcs[23:16];
            2'd3: fcs_byte = fcs[31:24];
        endcase
    end

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_last  = 1'b0;
        s_ready = 1'b0;
        unique case (state_q)
            IDLE, DATA: begin
                m_data  = s_axis_tdata_i;
                m_valid = s_axis_tvalid_i;
                s_ready = m_axis_tready_i;
                if (s_axis_tvalid_i && m_axis_tready_i) begin
                    crc_d   = crc_step(crc_q, s_axis_tdata_i);
                    cnt_d   = cnt_inc;
                    idx_d   = 2'd0;
                    state_d = DATA;
                    if (s_axis_tlast_i) begin
                        state_d = (cnt_nxt < MIN_L) ? PAD : FCS;
                    end
                end
            end
            PAD: begin
                m_valid = 1'b1;
                if (m_axis_tready_i) begin
                    crc_d = crc_step(crc_q, 8'h00);
                    cnt_d = cnt_inc;
                    if (cnt_nxt >= MIN_L) begin
                        state_d = FCS;
                    end
                end
            end
            FCS: begin
                m_valid = 1'b1;
                m_data  = fcs_byte;
                m_last  = (idx_q == 2'd3);
                if (m_axis_tready_i) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        done_d  = 1'b1;
                        len_d   = cnt_q + LEN_W'(4);
                        crc_d   = '1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            crc_q   <= '1;
            cnt_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Pass-through paths are combinational, so hold them quiet during reset
    assign m_axis_tdata_o  = rst ? 8'h00 : m_data;
    assign m_axis_tvalid_o = m_valid & ~rst;
    assign m_axis_tlast_o  = m_last & ~rst;
    assign s_axis_tready_o = s_ready & ~rst;
    assign frame_done_o    = done_q;
    assign frame_len_o     = len_q;

endmodule

// File: tb/tb_eth_fcs_append.sv
// Directed bench for eth_fcs_append: one instance without padding and one
// with the default 60-byte minimum, selected through a shared stimulus bus.
module tb_eth_fcs_append;

    typedef logic [7:0] bq_t[$];
    typedef bit         lq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        m_ready = 1'b0;

    logic [7:0]  d0, d1;
    logic        v0, v1, l0, l1, r0, r1, f0, f1;
    logic [15:0] n0, n1;

    logic [7:0]  m_data;
    logic        m_valid, m_last, s_ready, done;
    logic [15:0] flen;

    int vec = 0;
    int errs = 0;

    bq_t ob;
    lq_t ol;
    int  lens[$];

    always #5 clk = ~clk;

    eth_fcs_append #(.MIN_FRAME_LEN(0), .LEN_W(16)) u0 (
        .clk(clk), .rst(rst),
        .s_axis_tdata_i(s_data), .s_axis_tvalid_i(s_valid & ~sel),
        .s_axis_tready_o(r0), .s_axis_tlast_i(s_last),
        .m_axis_tdata_o(d0), .m_axis_tvalid_o(v0),
        .m_axis_tready_i(m_ready), .m_axis_tlast_o(l0),
        .frame_done_o(f0), .frame_len_o(n0)
    );

    eth_fcs_append u60 (
        .clk(clk), .rst(rst),
        .s_axis_tdata_i(s_data), .s_axis_tvalid_i(s_valid & sel),
        .s_axis_tready_o(r1), .s_axis_tlast_i(s_last),
        .m_axis_tdata_o(d1), .m_axis_tvalid_o(v1),
        .m_axis_tready_i(m_ready), .m_axis_tlast_o(l1),
        .frame_done_o(f1), .frame_len_o(n1)
    );

    assign m_data  = sel ? d1 : d0;
    assign m_valid = sel ? v1 : v0;
    assign m_last  = sel ? l1 : l0;
    assign s_ready = sel ? r1 : r0;
    assign done    = sel ? f1 : f0;
    assign flen    = sel ? n1 : n0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                            input logic [7:0]  b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic void add_exp(input bq_t f, input int minl,
                                    inout bq_t eb, inout lq_t el);
        bq_t p;
        logic [31:0] c;
        p = f;
        c = '1;
        while (p.size() < minl) p.push_back(8'h00);
        foreach (p[k]) c = crc_upd(c, p[k]);
        c = ~c;
        foreach (p[k]) begin
            eb.push_back(p[k]);
            el.push_back(1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            eb.push_back(c[8*k +: 8]);
            el.push_back(k == 3);
        end
    endfunction

    function automatic bq_t mk(input int n, input int seed);
        bq_t q;
        for (int k = 0; k < n; k++) q.push_back(8'((seed + k * 13) & 255));
        return q;
    endfunction

    function automatic lq_t mkl(input int n);
        lq_t q;
        for (int k = 0; k < n; k++) q.push_back(k == n - 1);
        return q;
    endfunction

    // Drives the input stream and records every output transfer.
    task automatic run(input bq_t ib, input lq_t il, input int nfr,
                       input bit rnd, input int max_out);
        int i = 0;
        int cyc = 0;
        bit acc;
        bit pst = 1'b0;
        logic [7:0] pd = 8'h00;
        logic pl = 1'b0;
        ob.delete();
        ol.delete();
        lens.delete();
        while (lens.size() < nfr && ob.size() < max_out && cyc < 4000) begin
            s_valid = (i < ib.size());
            s_data  = (i < ib.size()) ? ib[i] : 8'h00;
            s_last  = (i < ib.size()) ? il[i] : 1'b0;
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (pst) begin
                chk("stall_valid", {31'd0, m_valid}, 32'd1);
                chk("stall_data", {24'd0, m_data}, {24'd0, pd});
                chk("stall_last", {31'd0, m_last}, {31'd0, pl});
            end
            pst = m_valid && !m_ready;
            pd  = m_data;
            pl  = m_last;
            acc = s_valid && s_ready;
            if (m_valid && m_ready) begin
                ob.push_back(m_data);
                ol.push_back(m_last);
            end
            if (done) lens.push_back(int'(flen));
            @(posedge clk);
            #1;
            if (acc) i++;
            cyc++;
        end
        chk("no_timeout", {31'd0, cyc < 4000}, 32'd1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        if (max_out > ob.size()) begin
            @(negedge clk);
            chk("done_one_cycle", {31'd0, done}, 32'd0);
            if (lens.size() > 0)
                chk("len_hold", {16'd0, flen}, lens[lens.size()-1]);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cmp(input string tag, input bq_t eb, input lq_t el,
                       input int le[$]);
        chk({tag, "_nbytes"}, ob.size(), eb.size());
        for (int k = 0; k < eb.size() && k < ob.size(); k++) begin
            chk($sformatf("%s_byte%0d", tag, k), {24'd0, ob[k]},
                {24'd0, eb[k]});
            chk($sformatf("%s_last%0d", tag, k), {31'd0, ol[k]},
                {31'd0, el[k]});
        end
        chk({tag, "_ndone"}, lens.size(), le.size());
        for (int k = 0; k < le.size() && k < lens.size(); k++)
            chk($sformatf("%s_len%0d", tag, k), lens[k], le[k]);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tvalid"}, {31'd0, m_valid}, 32'd0);
        chk({tag, "_tlast"}, {31'd0, m_last}, 32'd0);
        chk({tag, "_tready"}, {31'd0, s_ready}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_len"}, {16'd0, flen}, 32'd0);
        chk({tag, "_tdata"}, {24'd0, m_data}, 32'd0);
    endtask

    initial begin
        bq_t s123, f16, f60, f100, fa, fb, eb, ib;
        lq_t el, il;
        int  le[$];

        s123 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                 8'h36, 8'h37, 8'h38, 8'h39};
        f16  = mk(16, 5);
        f60  = mk(60, 77);
        f100 = mk(100, 200);
        fa   = mk(16, 1);
        fb   = mk(20, 9);

        // Reset state with live-looking inputs on both instances
        s_valid = 1'b1;
        s_data  = 8'hA5;
        m_ready = 1'b1;
        #3;
        sel = 1'b0;
        #1 chk_zero("rst0");
        sel = 1'b1;
        #1 chk_zero("rst60");
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Check-value frame, no padding
        sel = 1'b0;
        eb = s123;
        el = mkl(9);
        el[8] = 1'b0;
        eb.push_back(8'h26); eb.push_back(8'h39);
        eb.push_back(8'hF4); eb.push_back(8'hCB);
        el.push_back(0); el.push_back(0); el.push_back(0); el.push_back(1);
        run(s123, mkl(9), 1, 1'b0, 1000);
        cmp("chk9", eb, el, '{13});

        // 16-byte frame padded to 60
        sel = 1'b1;
        eb.delete(); el.delete();
        add_exp(f16, 60, eb, el);
        run(f16, mkl(16), 1, 1'b0, 1000);
        cmp("pad16", eb, el, '{64});

        eb.delete(); el.delete();
        add_exp(f60, 60, eb, el);
        run(f60, mkl(60), 1, 1'b0, 1000);
        cmp("nopad60", eb, el, '{64});

        eb.delete(); el.delete();
        add_exp(f100, 60, eb, el);
        run(f100, mkl(100), 1, 1'b0, 1000);
        cmp("nopad100", eb, el, '{104});

        // Same 16-byte frame under random backpressure
        eb.delete(); el.delete();
        add_exp(f16, 60, eb, el);
        run(f16, mkl(16), 1, 1'b1, 1000);
        cmp("stall16", eb, el, '{64});

        // Back-to-back frames with tvalid held high throughout
        eb.delete(); el.delete(); ib.delete(); il.delete();
        add_exp(fa, 60, eb, el);
        add_exp(fb, 60, eb, el);
        ib = fa;
        foreach (fb[k]) ib.push_back(fb[k]);
        il = mkl(16);
        foreach (fb[k]) il.push_back(k == 19);
        run(ib, il, 2, 1'b0, 1000);
        cmp("b2b", eb, el, '{64, 64});

        // Reset in the middle of padding
        run(f16, mkl(16), 1, 1'b0, 20);
        chk("mid_pad_bytes", ob.size(), 20);
        rst = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        m_ready = 1'b1;
        #1 chk_zero("rstpad");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        s_valid = 1'b0;
        @(posedge clk);
        #1;

        eb.delete(); el.delete();
        add_exp(s123, 60, eb, el);
        run(s123, mkl(9), 1, 1'b0, 1000);
        cmp("post_rst60", eb, el, '{64});

        sel = 1'b0;
        eb = s123;
        el = mkl(9);
        el[8] = 1'b0;
        eb.push_back(8'h26); eb.push_back(8'h39);
        eb.push_back(8'hF4); eb.push_back(8'hCB);
        el.push_back(0); el.push_back(0); el.push_back(0); el.push_back(1);
        run(s123, mkl(9), 1, 1'b0, 1000);
        cmp("post_rst0", eb, el, '{13});

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
